// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: on a miss, streams BLOCK_WORDS word reads to main
// memory, writes returned words into the data array, then writes the tag.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_detected,
    input  logic [ADDR_W-1:0]              miss_address,
    input  logic                           memory_data_valid,
    input  logic [15:0]                    memory_data,
    output logic                           fsm_busy,
    output logic                           mem_rd_en,
    output logic [ADDR_W-1:0]              memory_address,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
    output logic [15:0]                    fill_data,
    output logic                           write_tag_array
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFF_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]    recv_cnt_q, recv_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

    assign fill_word_idx = recv_cnt_q[IDX_W-1:0];

    // Issue and receive sides run independently, so memory latency and valid gaps need no coupling.
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        issue_cnt_d      = issue_cnt_q;
        recv_cnt_d       = recv_cnt_q;
        fsm_busy         = 1'b0;
        mem_rd_en        = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_data        = '0;
        write_tag_array  = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    fsm_busy    = 1'b1;
                    base_d      = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (issue_cnt_q < CNT_FULL) begin
                    mem_rd_en      = 1'b1;
                    memory_address = base_q + ADDR_W'({issue_cnt_q, 1'b0});
                    issue_cnt_d    = issue_cnt_q + CNT_ONE;
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_data        = memory_data;
                    recv_cnt_d       = recv_cnt_q + CNT_ONE;
                    // The tag goes in with the last word so a hit can never see a partial block.
                    if (recv_cnt_q == CNT_LAST) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm with a 4-cycle pipelined memory model
// that can insert response gaps.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_rd_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word_idx;
    logic [15:0] fill_data;
    logic        write_tag_array;

    int total = 0;
    int bad   = 0;

    cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_rd_en         (mem_rd_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_idx     (fill_word_idx),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // Memory model: request seen in cycle c returns in cycle c+4; gap_after inserts a 2-cycle hole.
    bit          req_v = 1'b0;
    logic [15:0] req_a = '0;
    bit          line_v [4] = '{default: 1'b0};
    logic [15:0] line_a [4] = '{default: 16'h0};
    logic [15:0] pend_q [$];
    int          gap_after = -1;
    int          gap_left  = 0;
    int          deliv_cnt = 0;

    initial begin
        memory_data_valid = 1'b0;
        memory_data       = '0;
    end

    always @(negedge clk) begin
        req_v = mem_rd_en;
        req_a = memory_address;
    end

    always @(posedge clk) begin
        logic [15:0] a;
        #1;
        for (int k = 3; k > 0; k--) begin
            line_v[k] = line_v[k-1];
            line_a[k] = line_a[k-1];
        end
        line_v[0] = req_v;
        line_a[0] = req_a;
        if (line_v[3]) pend_q.push_back(line_a[3]);
        memory_data_valid = 1'b0;
        memory_data       = '0;
        if (gap_left > 0) begin
            gap_left--;
        end else if (pend_q.size() > 0) begin
            a = pend_q.pop_front();
            memory_data_valid = 1'b1;
            memory_data       = memWord(a);
            deliv_cnt++;
            if (deliv_cnt == gap_after + 1) gap_left = 2;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: logs requests, writes and tags relative to the cycle of the miss.
    bit          log_on = 1'b0;
    int          cyc = 0;
    int          busy_cnt = 0;
    logic [15:0] addr_log [$];
    int          addr_cyc [$];
    int          widx [$];
    logic [15:0] wdata [$];
    int          wcyc [$];
    int          tag_at [$];

    always @(negedge clk) begin
        if (log_on) begin
            if (fsm_busy) busy_cnt++;
            if (mem_rd_en) begin
                addr_log.push_back(memory_address);
                addr_cyc.push_back(cyc);
            end else begin
                checkOutput("addr_zero_when_idle", 32'(memory_address), 32'h0);
            end
            if (write_data_array) begin
                widx.push_back(int'(fill_word_idx));
                wdata.push_back(fill_data);
                wcyc.push_back(cyc);
            end
            if (write_tag_array) tag_at.push_back(write_data_array ? wdata.size() - 1 : -1);
            cyc++;
        end
    end

    task automatic startLog();
        addr_log.delete(); addr_cyc.delete();
        widx.delete(); wdata.delete(); wcyc.delete(); tag_at.delete();
        busy_cnt = 0;
        cyc      = 0;
        log_on   = 1'b1;
    endtask

    task automatic applyStimulus(input logic miss, input logic [15:0] addr);
        @(posedge clk);
        #1;
        miss_detected = miss;
        miss_address  = addr;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (fsm_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (fsm_busy) checkOutput("wait_idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
        log_on = 1'b0;
    endtask

    task automatic checkLog(input logic [15:0] base0, input logic [15:0] base1, input int nfills,
                            input int exp_busy, input int exp_last_wr);
        logic [15:0] e;
        checkOutput("issue_count", 32'(addr_log.size()), 32'(8 * nfills));
        checkOutput("write_count", 32'(wdata.size()), 32'(8 * nfills));
        checkOutput("tag_count", 32'(tag_at.size()), 32'(nfills));
        checkOutput("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        for (int i = 0; i < addr_log.size() && i < 8 * nfills; i++) begin
            e = ((i < 8) ? base0 : base1) + 16'(2 * (i % 8));
            checkOutput($sformatf("req_addr[%0d]", i), 32'(addr_log[i]), 32'(e));
        end
        for (int i = 0; i < wdata.size() && i < 8 * nfills; i++) begin
            e = ((i < 8) ? base0 : base1) + 16'(2 * (i % 8));
            checkOutput($sformatf("fill_idx[%0d]", i), 32'(widx[i]), 32'(i % 8));
            checkOutput($sformatf("fill_data[%0d]", i), 32'(wdata[i]), 32'(memWord(e)));
        end
        for (int j = 0; j < tag_at.size() && j < nfills; j++)
            checkOutput($sformatf("tag_with_word[%0d]", j), 32'(tag_at[j]), 32'(8 * j + 7));
        if (addr_cyc.size() > 0) checkOutput("first_req_cycle", 32'(addr_cyc[0]), 32'd1);
        if (wcyc.size() > 0) begin
            checkOutput("first_write_cycle", 32'(wcyc[0]), 32'd5);
            checkOutput("last_write_cycle", 32'(wcyc[wcyc.size()-1]), 32'(exp_last_wr));
        end
    endtask

    task automatic checkResetOutputs(input string tag, input logic exp_busy);
        checkOutput({tag, "_busy"}, 32'(fsm_busy), 32'(exp_busy));
        checkOutput({tag, "_rd_en"}, 32'(mem_rd_en), 32'h0);
        checkOutput({tag, "_addr"}, 32'(memory_address), 32'h0);
        checkOutput({tag, "_wr_data"}, 32'(write_data_array), 32'h0);
        checkOutput({tag, "_idx"}, 32'(fill_word_idx), 32'h0);
        checkOutput({tag, "_fill_data"}, 32'(fill_data), 32'h0);
        checkOutput({tag, "_wr_tag"}, 32'(write_tag_array), 32'h0);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] exp_base;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{addr: 16'h1236, exp_base: 16'h1230};
        vecs[1] = '{addr: 16'h0008, exp_base: 16'h0000};
        vecs[2] = '{addr: 16'hFFFA, exp_base: 16'hFFF0};
        vecs[3] = '{addr: 16'h000F, exp_base: 16'h0000};
        vecs[4] = '{addr: 16'h1230, exp_base: 16'h1230};
        vecs[5] = '{addr: 16'hABCD, exp_base: 16'hABC0};

        rst_n         = 1'b0;
        miss_detected = 1'b0;
        miss_address  = '0;

        // Reset state, and busy following the miss input even while held in reset.
        repeat (2) @(negedge clk);
        checkResetOutputs("reset", 1'b0);
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        @(negedge clk);
        checkResetOutputs("reset_miss", 1'b1);
        miss_detected = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkResetOutputs("post_reset_idle", 1'b0);

        // Table: base alignment and first request timing for several miss addresses.
        for (int v = 0; v < 6; v++) begin
            applyStimulus(1'b1, vecs[v].addr);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_busy_on_miss", v), 32'(fsm_busy), 32'h1);
            checkOutput($sformatf("vec%0d_no_req_on_miss", v), 32'(mem_rd_en), 32'h0);
            applyStimulus(1'b0, 16'h0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_req0_en", v), 32'(mem_rd_en), 32'h1);
            checkOutput($sformatf("vec%0d_req0_addr", v), 32'(memory_address), 32'(vecs[v].exp_base));
            applyStimulus(1'b0, 16'h0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_req1_addr", v), 32'(memory_address), 32'(vecs[v].exp_base + 16'h2));
            @(posedge clk);
            #2 rst_n = 1'b0;
            @(posedge clk);
            #2 rst_n = 1'b1;
            repeat (10) applyStimulus(1'b0, 16'h0);
        end

        // Basic fill.
        applyStimulus(1'b1, 16'h1236);
        startLog();
        applyStimulus(1'b0, 16'h0);
        waitIdle(40);
        checkLog(16'h1230, 16'h0, 1, 13, 12);
        repeat (3) applyStimulus(1'b0, 16'h0);

        // Miss during fill must be ignored.
        applyStimulus(1'b1, 16'h1236);
        startLog();
        applyStimulus(1'b0, 16'h0);
        applyStimulus(1'b0, 16'h0);
        applyStimulus(1'b1, 16'h4440);
        applyStimulus(1'b1, 16'h4440);
        applyStimulus(1'b0, 16'h0);
        waitIdle(40);
        checkLog(16'h1230, 16'h0, 1, 13, 12);
        repeat (3) applyStimulus(1'b0, 16'h0);

        // Two-cycle valid gap after word 3.
        deliv_cnt = 0;
        gap_after = 3;
        applyStimulus(1'b1, 16'h1236);
        startLog();
        applyStimulus(1'b0, 16'h0);
        waitIdle(40);
        gap_after = -1;
        checkLog(16'h1230, 16'h0, 1, 15, 14);
        repeat (3) applyStimulus(1'b0, 16'h0);

        // Back-to-back fills, second in the first IDLE cycle, near the top of the address space.
        applyStimulus(1'b1, 16'h1236);
        startLog();
        repeat (12) applyStimulus(1'b0, 16'h0);
        applyStimulus(1'b1, 16'hFFFA);
        applyStimulus(1'b0, 16'h0);
        waitIdle(60);
        checkLog(16'h1230, 16'hFFF0, 2, 26, 25);
        repeat (3) applyStimulus(1'b0, 16'h0);

        // Reset mid-fill after three words, then a fresh fill.
        applyStimulus(1'b1, 16'h1236);
        startLog();
        applyStimulus(1'b0, 16'h0);
        begin
            int n;
            n = 0;
            while (wdata.size() < 3 && n < 30) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (wdata.size() < 3) checkOutput("wait_three_words_timeout", 32'd1, 32'd0);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkResetOutputs("midfill_reset", 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) applyStimulus(1'b0, 16'h0);
        @(negedge clk);
        log_on = 1'b0;
        checkOutput("abandoned_writes", 32'(wdata.size()), 32'd3);
        checkOutput("abandoned_tag_count", 32'(tag_at.size()), 32'd0);
        applyStimulus(1'b1, 16'h0008);
        startLog();
        applyStimulus(1'b0, 16'h0);
        waitIdle(40);
        checkLog(16'h0000, 16'h0, 1, 13, 12);

        repeat (3) applyStimulus(1'b0, 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule
